// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with 16x oversampling and 2-of-3 majority bit voting
//
// Recovers framed bytes from the asynchronous serial line and writes each good
// byte straight into the downstream receive FIFO. There is no backpressure.
//
// Ports:
//   uart_clk  in   sole clock, rising edge, OVERSAMPLE x baud
//   rst_n     in   asynchronous reset, active HIGH (1 = reset asserted)
//   uart_rxd  in   serial line, idle high, asynchronous to uart_clk
//   rf_data   out  last correctly framed byte (FIFO write data)
//   fr_wrreq  out  one-cycle FIFO write request per good frame
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 uart_clk,
    input  logic                 rst_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rf_data,
    output logic                 fr_wrreq
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    // The tick counter is cleared on the edge that first sees the start bit, so
    // the counter value seen at edge D+n is n-1. Sampling at counter values
    // 6/7/8 therefore lands on edges D+16k+7/8/9 of each bit window.
    localparam logic [TW-1:0] TICK_S0  = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [TW-1:0] TICK_S1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_DEC = TW'(OVERSAMPLE / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic                 sync1_q, sync2_q, rxd_prev_q;
    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 samp_a_q, samp_a_d;
    logic                 samp_b_q, samp_b_d;
    logic [DATA_BITS-1:0] rf_data_q, rf_data_d;
    logic                 wrreq_q, wrreq_d;

    logic rxd_s;
    logic rxd_edge;
    logic vote;

    assign rxd_s    = sync2_q;
    assign rxd_edge = rxd_s ^ rxd_prev_q;
    // Third sample is taken live at the decision tick.
    assign vote     = (samp_a_q & samp_b_q) | (samp_a_q & rxd_s) | (samp_b_q & rxd_s);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        samp_a_d  = samp_a_q;
        samp_b_d  = samp_b_q;
        rf_data_d = rf_data_q;
        wrreq_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_d = S_START;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            S_START, S_DATA, S_STOP: begin
                tick_d = tick_q + TW'(1);
                if (tick_q == TICK_S0) samp_a_d = rxd_s;
                if (tick_q == TICK_S1) samp_b_d = rxd_s;
                // A line transition outside the sampling window marks a bit
                // boundary: restart the window there. At the nominal rate the
                // boundary coincides with the natural wrap, so nothing moves;
                // with a skewed sender it keeps samples centred across runs.
                if (rxd_edge && (tick_q < TICK_S0 || tick_q > TICK_DEC)) begin
                    tick_d = '0;
                end
                if (tick_q == TICK_DEC) begin
                    case (state_q)
                        S_START: state_d = vote ? S_IDLE : S_DATA;
                        S_DATA: begin
                            shift_d = {vote, shift_q[DATA_BITS-1:1]};
                            bit_d   = bit_q + BW'(1);
                            if (bit_q == BIT_LAST) state_d = S_STOP;
                        end
                        default: begin
                            // Leaving at mid-stop-bit lets a start bit that
                            // follows immediately be caught.
                            if (vote) begin
                                rf_data_d = shift_q;
                                wrreq_d   = 1'b1;
                                state_d   = S_IDLE;
                            end else begin
                                state_d   = S_WAIT_IDLE;
                            end
                        end
                    endcase
                end
            end
            S_WAIT_IDLE: begin
                if (rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge uart_clk or posedge rst_n) begin
        if (rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            samp_a_q   <= 1'b1;
            samp_b_q   <= 1'b1;
            rf_data_q  <= '0;
            wrreq_q    <= 1'b0;
        end else begin
            sync1_q    <= uart_rxd;
            sync2_q    <= sync1_q;
            rxd_prev_q <= sync2_q;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            samp_a_q   <= samp_a_d;
            samp_b_q   <= samp_b_d;
            rf_data_q  <= rf_data_d;
            wrreq_q    <= wrreq_d;
        end
    end

    assign rf_data  = rf_data_q;
    assign fr_wrreq = wrreq_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver
`timescale 1ns/1ps
module tb_uart_receiver;

    logic       uart_clk = 1'b0;
    logic       rst_n    = 1'b1;
    logic       uart_rxd = 1'b1;
    logic [7:0] rf_data;
    logic       fr_wrreq;

    uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .uart_clk (uart_clk),
        .rst_n    (rst_n),
        .uart_rxd (uart_rxd),
        .rf_data  (rf_data),
        .fr_wrreq (fr_wrreq)
    );

    // 153.6 kHz -> ~6.51 us period
    always #3255 uart_clk = ~uart_clk;

    int cyc = 0;
    always @(posedge uart_clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         at;   // expected cyc value while fr_wrreq is high, -1 = don't care
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: sample away from the active edge, pop and compare on each pulse.
    initial begin
        logic prev_wr;
        exp_t e;
        prev_wr = 1'b0;
        forever begin
            @(negedge uart_clk);
            if (fr_wrreq) begin
                check("pulse_width", int'(prev_wr), 0);
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_pulse: got rf_data 0x%0h at cyc %0d, expected no pulse", rf_data, cyc);
                end else begin
                    e = sb.pop_front();
                    check("rf_data", int'(rf_data), int'(e.data));
                    if (e.at >= 0) check("pulse_cycle", cyc, e.at);
                end
            end
            prev_wr = fr_wrreq;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge uart_clk);
        #1;
    endtask

    // Called just after a rising edge. Line goes low now (cyc = P0): first
    // sampled at P0+1, seen by the FSM at D = P0+3, pulse sampled at D+154,
    // so it is high while cyc = P0+156.
    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit,
                              input logic expect_ok);
        logic [9:0] bits;
        exp_t e;
        bits = {stop_bit, b, 1'b0};
        if (expect_ok) begin
            e.data = b;
            e.at   = (per == 16) ? cyc + 156 : -1;
            sb.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            wait_cyc(per);
        end
    endtask

    initial begin
        logic [7:0] ab;
        logic [7:0] b2b [4];
        b2b[0] = 8'hA5; b2b[1] = 8'h3C; b2b[2] = 8'h00; b2b[3] = 8'hFF;

        // reset state
        wait_cyc(4);
        check("reset_rf_data", int'(rf_data), 0);
        check("reset_fr_wrreq", int'(fr_wrreq), 0);
        rst_n = 1'b0;
        wait_cyc(160);

        // single byte with latency check
        send_frame(8'h55, 16, 1'b1, 1'b1);
        wait_cyc(32);

        // back-to-back, no idle between frames
        for (int i = 0; i < 4; i++) send_frame(b2b[i], 16, 1'b1, 1'b1);
        wait_cyc(32);

        // glitch rejection
        uart_rxd = 1'b0;
        wait_cyc(4);
        uart_rxd = 1'b1;
        wait_cyc(48);
        send_frame(8'h81, 16, 1'b1, 1'b1);
        wait_cyc(32);

        // framing error: stop bit low, line held low 3 more bit times
        send_frame(8'h33, 16, 1'b0, 1'b0);
        wait_cyc(48);
        uart_rxd = 1'b1;
        wait_cyc(32);
        check("framing_rf_data_held", int'(rf_data), 8'h81);
        send_frame(8'hC3, 16, 1'b1, 1'b1);
        wait_cyc(32);

        // reset during data bit 4
        ab = 8'h5A;
        uart_rxd = 1'b0;
        wait_cyc(16);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = ab[i];
            wait_cyc(16);
        end
        uart_rxd = ab[4];
        wait_cyc(8);
        #2 rst_n = 1'b1;
        #1;
        check("midreset_rf_data", int'(rf_data), 0);
        check("midreset_fr_wrreq", int'(fr_wrreq), 0);
        uart_rxd = 1'b1;
        wait_cyc(5);
        rst_n = 1'b0;
        wait_cyc(64);
        send_frame(8'h5A, 16, 1'b1, 1'b1);
        wait_cyc(32);

        // baud skew
        send_frame(8'h96, 15, 1'b1, 1'b1);
        wait_cyc(48);
        send_frame(8'h96, 17, 1'b1, 1'b1);
        wait_cyc(48);

        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART serial receiver for the S4 UART path: recovers 8N1 frames from the asynchronous `uart_rxd` line using 16× oversampling on `uart_clk`. Each correctly framed byte is presented on `rf_data` with a single-cycle `fr_wrreq` pulse. These outputs drive the write side of the downstream receive FIFO directly. The block needs no CPU or host interaction.

## Interface
- `OVERSAMPLE`, default 16: `uart_clk` cycles per bit (`uart_clk` = baud × 16, e.g. 153 600 Hz for 9600 baud); fixed at 16 for this design.
- `DATA_BITS`, default 8: data bits per frame, LSB first.
- `uart_clk`  in  1  sole clock, rising-edge, 16× baud.
- `rst_n`  in  1  asynchronous, active-high reset (1 = reset asserted); one clock domain, no other reset.
- `uart_rxd`  in  1  serial line, idle high, asynchronous to `uart_clk`.
- `rf_data`  out  8  last valid received byte; FIFO write data.
- `fr_wrreq`  out  1  FIFO write request, one-cycle pulse per valid frame.

## Operation
- Input conditioning:
  - `uart_rxd` passes through a 2-flop synchronizer; reset value of both flops is 1.
  - All logic uses the synchronized signal `rxd_s`.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
- State machine: IDLE, START, DATA, STOP, WAIT_IDLE.
  - **IDLE**: on `rxd_s` = 0, go to START and clear tick counter (0..15) and bit index.
  - **Bit sampling**: every bit is sampled at ticks 7, 8 and 9 of its 16-tick window; the bit value is the 2-of-3 majority vote.
  - **START**: majority = 1 is a false start (glitch); return to IDLE, no output. Majority = 0: go to DATA.
  - **DATA**: shift majority into bit index 0..7 (LSB first); after bit 7, go to STOP.
  - **STOP, majority = 1**: load the shift register into `rf_data`, pulse `fr_wrreq`, return to IDLE. Return is at mid-stop-bit, so a start bit immediately following is caught.
  - **STOP, majority = 0 (framing error)**: discard the byte, no pulse, `rf_data` unchanged; go to WAIT_IDLE.
  - **WAIT_IDLE**: stay until `rxd_s` = 1, then go to IDLE (covers line break).
- `rf_data` holds its value between frames and changes only when `fr_wrreq` pulses.
- There is no backpressure; the downstream FIFO must accept every pulse.

## Timing
- Reset values: `rf_data` = 8'h00, `fr_wrreq` = 0, state IDLE, counters 0, synchronizer flops 1.
  - Reset takes effect immediately, including mid-frame; the partial frame is dropped.
  - After release, the block waits in IDLE for a falling line.
- Define D as the first rising edge at which `rxd_s` = 0 in IDLE. D is 2 edges after `uart_rxd` is first sampled low.
  - Bit k (0 = start, 1–8 = data, 9 = stop) is sampled at edges D+16k+7, D+16k+8 and D+16k+9.
  - The bit decision is made at edge D+16k+9.
- `fr_wrreq` is high for exactly one cycle, at edge D+154 (cycle after the stop decision).
  - `rf_data` is valid in that same cycle.
  - Total latency from the start-bit falling edge to `fr_wrreq` is about 156 `uart_clk` cycles (~9.75 bit times).
- Clock tolerance: a bit period of 15–17 `uart_clk` cycles (±~6%) must decode correctly.
- Back-to-back frames, with a start bit directly after the stop bit, are received with no gap.

## Test plan
- **Single byte**:
  - Stimulus: 9600 baud, 153.6 kHz clock; hold line idle 10 bit times after reset; send frame 0x55 (bit period 104 µs).
  - Required response: `rf_data` = 0x55; exactly one `fr_wrreq` pulse, one cycle wide, at D+154.
- **Back-to-back**:
  - Stimulus: frames 0xA5, 0x3C, 0x00, 0xFF with zero idle between them.
  - Required response: four pulses, data in order.
- **Glitch rejection**:
  - Stimulus: `uart_rxd` low for 4 cycles, then high.
  - Required response: no `fr_wrreq`; the block returns to IDLE and then receives 0x81 correctly.
- **Framing error**:
  - Stimulus: send 0x33 with stop bit = 0, hold line low 3 bit times, then release.
  - Required response: no pulse and `rf_data` unchanged; a following 0xC3 frame is received correctly.
- **Reset mid-frame**:
  - Stimulus: assert `rst_n` = 1 during data bit 4.
  - Required response: outputs go to 0 immediately; no pulse for the aborted frame; the next full frame 0x5A is received.
- **Baud skew**:
  - Stimulus: send 0x96 with bit period 15 cycles, then with bit period 17 cycles.
  - Required response: both frames decode to 0x96.
